// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH serial bits (MSB- or LSB-first per frame)
// into a word on a valid/ready output and pulses overrun on a dropped word.
// Optional parity check (one trailing parity bit, parity_err port) under `PARITY_CHECK_EN.
module shift_deser #(
    parameter int          WIDTH   = 4,
    parameter int unsigned PAR_ODD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    input  logic             msb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
`ifdef PARITY_CHECK_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || PAR_ODD > 1) begin : g_param_chk
        $error("shift_deser: WIDTH must be >= 2 and PAR_ODD must be 0 or 1");
    end

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic             msb_r, msb_nxt;
    logic             done;
    logic [WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
    logic             par_bad;
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b, input logic msb);
        return msb ? {cur[WIDTH-2:0], b} : {b, cur[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            msb_r <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
            msb_r <= msb_nxt;
        end
    end

    // An accepted sof always (re)starts a frame, whatever the current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        msb_nxt   = msb_r;
        done      = 1'b0;
        word      = sr;
`ifdef PARITY_CHECK_EN
        par_bad   = 1'b0;
`endif
        if (sin_valid) begin
            if (sof) begin
                msb_nxt   = msb_first;
                sr_nxt    = shift_in('0, sin, msb_first);
                cnt_nxt   = CNT_W'(1);
                state_nxt = SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        sr_nxt = shift_in(sr, sin, msb_r);
                        if (cnt == LAST) begin
                            cnt_nxt   = '0;
`ifdef PARITY_CHECK_EN
                            state_nxt = PAR;
`else
                            done      = 1'b1;
                            word      = sr_nxt;
                            state_nxt = IDLE;
`endif
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PAR: begin
                        done      = 1'b1;
                        word      = sr;
                        par_bad   = sin != (^sr ^ PAR_ODD[0]);
                        state_nxt = IDLE;
                    end
`endif
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Output register: a completed word lands only if the slot is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= done & par_bad;
`endif
            if (done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= word;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deser.sv
// Directed self-checking bench for shift_deser (WIDTH=4); parity cases run
// only when PARITY_CHECK_EN is defined.
module tb_shift_deser;

    localparam int          WIDTH   = 4;
    localparam int unsigned PAR_ODD = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sin, sin_valid, sof, msb_first, dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, overrun;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    shift_deser #(.WIDTH(WIDTH), .PAR_ODD(PAR_ODD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sof        (sof),
        .msb_first  (msb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef PARITY_CHECK_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        sin_valid = 1'b0;
        sof       = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_bit(input logic b, input logic s, input logic m);
        sin       = b;
        sof       = s;
        msb_first = m;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Sends one frame; with lat set, dout_valid must still be low just before the completing bit.
    task automatic send_frame(input logic [WIDTH-1:0] w, input logic m, input int gaps,
                              input bit lat, input bit bad_par);
        logic [WIDTH-1:0] wv;
        wv = w;
        for (int i = 0; i < WIDTH; i++) begin
`ifndef PARITY_CHECK_EN
            if (lat && i == WIDTH - 1) chk("latency_pre", {31'd0, dout_valid}, 32'd0);
`endif
            send_bit(m ? wv[WIDTH-1-i] : wv[i], i == 0, m);
            if (gaps > 0 && i < WIDTH - 1) gap(gaps);
        end
`ifdef PARITY_CHECK_EN
        if (lat) chk("latency_pre", {31'd0, dout_valid}, 32'd0);
        send_bit((^wv) ^ PAR_ODD[0] ^ bad_par, 1'b0, m);
`endif
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] d, input logic v, input logic o);
        chk({tag, "_dout"}, {28'd0, dout}, {28'd0, d});
        chk({tag, "_valid"}, {31'd0, dout_valid}, {31'd0, v});
        chk({tag, "_ovr"}, {31'd0, overrun}, {31'd0, o});
    endtask

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
        msb_first = 1'b0; dout_ready = 1'b1;
        tick(); tick();
        chk_out("reset", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Test 1: async reset with a held word and a partial frame in flight
        dout_ready = 1'b0;
        send_frame(4'b1101, 1'b1, 0, 1'b0, 1'b0);
        chk_out("t1_held", 4'b1101, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_out("t1_async_rst", 4'b0000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        chk("t1_no_sof_ignored", {31'd0, dout_valid}, 32'd0);
        send_frame(4'b1101, 1'b1, 0, 1'b0, 1'b0);
        chk_out("t1_clean", 4'b1101, 1'b1, 1'b0);
        gap(1);
        chk_out("t1_drain", 4'b1101, 1'b0, 1'b0);

        // Test 2: MSB-first latency, then a back-to-back frame
        send_frame(4'b1101, 1'b1, 0, 1'b1, 1'b0);
        chk_out("t2_msb", 4'b1101, 1'b1, 1'b0);
        send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b0);
        chk_out("t2_b2b", 4'b0110, 1'b1, 1'b0);
        gap(1);

        // Test 3: LSB-first, without and with gaps
        send_frame(4'b1101, 1'b0, 0, 1'b1, 1'b0);
        chk_out("t3_lsb", 4'b1101, 1'b1, 1'b0);
        send_frame(4'b0110, 1'b0, 0, 1'b0, 1'b0);
        chk_out("t3_lsb2", 4'b0110, 1'b1, 1'b0);
        gap(1);
        send_frame(4'b1101, 1'b0, 2, 1'b1, 1'b0);
        chk_out("t3_gaps", 4'b1101, 1'b1, 1'b0);
        gap(1);

        // Test 4: overrun while the consumer stalls
        dout_ready = 1'b0;
        send_frame(4'b1101, 1'b1, 0, 1'b0, 1'b0);
        chk_out("t4_first", 4'b1101, 1'b1, 1'b0);
        send_frame(4'b0010, 1'b1, 0, 1'b0, 1'b0);
        chk_out("t4_drop", 4'b1101, 1'b1, 1'b1);
        gap(1);
        chk_out("t4_pulse_end", 4'b1101, 1'b1, 1'b0);
        dout_ready = 1'b1;
        gap(1);
        chk_out("t4_release", 4'b1101, 1'b0, 1'b0);

        // Test 5: sof mid-frame restarts and re-samples bit order
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_frame(4'b0010, 1'b1, 0, 1'b1, 1'b0);
        chk_out("t5_restart_msb", 4'b0010, 1'b1, 1'b0);
        gap(1);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_frame(4'b0100, 1'b0, 0, 1'b1, 1'b0);
        chk_out("t5_restart_lsb", 4'b0100, 1'b1, 1'b0);
        gap(1);

`ifdef PARITY_CHECK_EN
        // Test 6: parity good then bad
        send_frame(4'b1101, 1'b1, 0, 1'b0, 1'b0);
        chk_out("t6_good", 4'b1101, 1'b1, 1'b0);
        chk("t6_good_perr", {31'd0, parity_err}, 32'd0);
        gap(1);
        send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b1);
        chk_out("t6_bad", 4'b0110, 1'b1, 1'b0);
        chk("t6_bad_perr", {31'd0, parity_err}, 32'd1);
        gap(1);
        chk("t6_perr_end", {31'd0, parity_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
